branch_resolve: RTL and testbench
=================================

# branch_resolve

Execute-stage branch resolution unit. It evaluates every branch arriving from ex0 and compares the outcome against the fetch-time prediction carried down the pipe. On a mismatch it issues a one-cycle redirect/flush to fetch. It queues one update record per resolved branch toward the BTB's `fact_*`/`predict_*_fail` update port and keeps prediction statistics counters.

## Interface
Parameters:
- `UPD_DEPTH`, default 4: update FIFO entries; must be a power of two, ≥2.
- `CNT_WIDTH`, default 32: width of the statistics counters.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `ex_valid`  in  1  a valid instruction is in ex0 this cycle.
- `ex_pc`  in  32  PC of the ex0 instruction.
- `ex_br_op`  in  4  branch op: 0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 B, 8 BL, 9 JIRL; 10–15 are treated as none.
- `ex_rj`, `ex_rd`  in  32 each  forwarded source operands.
- `ex_offs`  in  32  sign-extended, already-shifted branch offset.
- `ex_pred_taken`  in  1  prediction made at fetch.
- `ex_pred_pc`  in  32  predicted next PC made at fetch.
- `flush`  out  1  redirect pulse to fetch and the front-end stages.
- `flush_pc`  out  32  correct next PC; meaningful only while `flush`=1.
- `upd_valid`  out  1  FIFO head is valid.
- `upd_ready`  in  1  BTB accepts the head this cycle.
- `upd_pc`, `upd_tpc`  out  32 each  branch PC and computed target.
- `upd_taken`, `upd_dir_fail`, `upd_add_fail`  out  1 each  resolved direction and failure flags.
- `br_cnt`, `miss_cnt`, `drop_cnt`  out  `CNT_WIDTH` each  resolved branches, mispredicts, and dropped update records.

## Operation
- A branch is resolved when `ex_valid`=1, `ex_br_op` is in 1..9, and the state is RUN.
- Compare rules:
  - BEQ/BNE: equality test on rj, rd.
  - BLT/BGE: signed compare of rj vs rd.
  - BLTU/BGEU: unsigned compare of rj vs rd.
  - B, BL, JIRL: always taken.
- Target:
  - JIRL: `rj + offs`.
  - All other branches: `pc + offs`.
  - All additions are 32-bit and wrap modulo 2^32.
- Failure flags:
  - `dir_fail` = taken ≠ `pred_taken`.
  - `add_fail` = taken & `pred_taken` & (target ≠ `pred_pc`).
  - Mispredict = `dir_fail | add_fail`.
- Correct next PC = taken ? target : `pc+4`.
- Two-state FSM:
  - RUN → FLUSH on a resolved mispredict; `flush`=1 and `flush_pc` = correct next PC during the FLUSH cycle.
  - FLUSH → RUN unconditionally after one cycle.
  - In FLUSH, `ex_valid` is ignored: the instruction is wrong-path, so no push, no count and no flush.
- Update FIFO:
  - Every resolved branch, predicted correctly or not, pushes {pc, target, taken, dir_fail, add_fail}.
  - A pop occurs when `upd_valid & upd_ready`.
  - Push and pop in the same cycle are both performed, including when the FIFO is full, because the pop frees the slot.
  - Push while full without a pop: the new record is discarded and `drop_cnt` increments; contents are unchanged.
  - Empty: `upd_valid`=0 and the head fields hold their last value.
- Counters: `br_cnt` increments per resolved branch; `miss_cnt` increments per mispredict. All counters saturate at their all-ones value.
- Reset mid-operation clears the FSM, FIFO pointers and counters immediately; any pending flush is cancelled.

## Timing
- Reset values:
  - `flush`=0, `flush_pc`=0.
  - `upd_valid`=0; `upd_pc`, `upd_tpc`, `upd_taken`, `upd_dir_fail`, `upd_add_fail` all 0.
  - All counters 0; state RUN.
- Resolution is combinational in the cycle the branch sits in ex0 (cycle t).
- Effects of a branch resolved in cycle t:
  - `flush`/`flush_pc` are registered and visible in t+1 for exactly one cycle.
  - The FIFO entry is written at the end of t; `upd_valid` rises in t+1 if the FIFO was empty.
  - Counters show the new value in t+1.
- Outputs are registered except `upd_*`, which are the FIFO head registers.
- Back-to-back mispredicts are impossible by construction: the cycle after a flush is always discarded.

## Test plan
- BEQ, rj=rd=5, pc=0x1C000100, offs=0x40, pred_taken=1, pred_pc=0x1C000140 → no flush; entry {0x1C000100, 0x1C000140, taken=1, 0, 0}; `br_cnt`=1, `miss_cnt`=0.
- BLT, rj=0xFFFFFFFF, rd=1, pred_taken=0 → taken (signed compare); `flush` in t+1 with `flush_pc`=pc+offs; `dir_fail`=1. The same operands with BLTU → not taken, no flush.
- JIRL, rj=0x1C002000, offs=8, pred_taken=1, pred_pc=0x1C003000 → `add_fail`=1, `flush_pc`=0x1C002008. A valid branch in the FLUSH cycle is ignored: `br_cnt` is unchanged.
- `upd_ready`=0 while 5 branches resolve → the first 4 are queued and `drop_cnt`=1. Then hold `upd_ready`=1 with a simultaneous push → the FIFO stays at 4 entries and drains in order.
- pc=0xFFFFFFF0, B offs=0x20 → target 0x00000010 (wrap-around).
- Assert `rstn`=0 in the cycle after a mispredict → `flush`=0 immediately; FIFO empty; counters 0.

Source files
------------

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: evaluates ex0 branches against the fetch prediction,
// raises a one-cycle redirect on mispredict, queues BTB update records and keeps statistics.
module branch_resolve #(
    parameter int unsigned UPD_DEPTH = 4,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 ex_valid,
    input  logic [31:0]          ex_pc,
    input  logic [3:0]           ex_br_op,
    input  logic [31:0]          ex_rj,
    input  logic [31:0]          ex_rd,
    input  logic [31:0]          ex_offs,
    input  logic                 ex_pred_taken,
    input  logic [31:0]          ex_pred_pc,
    output logic                 flush,
    output logic [31:0]          flush_pc,
    output logic                 upd_valid,
    input  logic                 upd_ready,
    output logic [31:0]          upd_pc,
    output logic [31:0]          upd_tpc,
    output logic                 upd_taken,
    output logic                 upd_dir_fail,
    output logic                 upd_add_fail,
    output logic [CNT_WIDTH-1:0] br_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    localparam int unsigned PTR_W  = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
    localparam int unsigned FILL_W = PTR_W + 1;

    localparam logic [3:0] OP_BEQ  = 4'd1;
    localparam logic [3:0] OP_BNE  = 4'd2;
    localparam logic [3:0] OP_BLT  = 4'd3;
    localparam logic [3:0] OP_BGE  = 4'd4;
    localparam logic [3:0] OP_BLTU = 4'd5;
    localparam logic [3:0] OP_BGEU = 4'd6;
    localparam logic [3:0] OP_B    = 4'd7;
    localparam logic [3:0] OP_BL   = 4'd8;
    localparam logic [3:0] OP_JIRL = 4'd9;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tpc;
        logic        taken;
        logic        dir_fail;
        logic        add_fail;
    } upd_rec_t;

    state_t      state_q;
    state_t      state_d;
    logic        flush_d;
    logic [31:0] flush_pc_d;

    logic        is_branch;
    logic        taken;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        dir_fail;
    logic        add_fail;
    logic        mispredict;
    logic        resolve;

    // Combinational resolution of the instruction sitting in ex0
    always_comb begin
        is_branch = 1'b1;
        taken     = 1'b0;
        unique case (ex_br_op)
            OP_BEQ:  taken = (ex_rj == ex_rd);
            OP_BNE:  taken = (ex_rj != ex_rd);
            OP_BLT:  taken = ($signed(ex_rj) < $signed(ex_rd));
            OP_BGE:  taken = !($signed(ex_rj) < $signed(ex_rd));
            OP_BLTU: taken = (ex_rj < ex_rd);
            OP_BGEU: taken = !(ex_rj < ex_rd);
            OP_B, OP_BL, OP_JIRL: taken = 1'b1;
            default: is_branch = 1'b0;
        endcase
        target     = ((ex_br_op == OP_JIRL) ? ex_rj : ex_pc) + ex_offs;
        next_pc    = taken ? target : (ex_pc + 32'd4);
        dir_fail   = taken ^ ex_pred_taken;
        add_fail   = taken & ex_pred_taken & (target != ex_pred_pc);
        mispredict = dir_fail | add_fail;
        resolve    = ex_valid & is_branch & (state_q == ST_RUN);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_RUN;
            flush    <= 1'b0;
            flush_pc <= 32'd0;
        end else begin
            state_q  <= state_d;
            flush    <= flush_d;
            flush_pc <= flush_pc_d;
        end
    end

    // The FLUSH cycle holds a wrong-path instruction, so it is never resolved
    always_comb begin
        state_d    = state_q;
        flush_d    = 1'b0;
        flush_pc_d = flush_pc;
        unique case (state_q)
            ST_RUN: begin
                if (resolve && mispredict) begin
                    state_d    = ST_FLUSH;
                    flush_d    = 1'b1;
                    flush_pc_d = next_pc;
                end
            end
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    upd_rec_t              mem [UPD_DEPTH];
    upd_rec_t              new_rec;
    upd_rec_t              head_q;
    upd_rec_t              head_d;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_d;
    logic [FILL_W-1:0]     fill_q;
    logic [FILL_W-1:0]     fill_d;
    logic [FILL_W-1:0]     remain;
    logic                  full;
    logic                  pop;
    logic                  push_ok;
    logic                  drop;

    // A pop frees the slot, so a push into a full FIFO still lands when the head leaves
    always_comb begin
        new_rec  = '{pc: ex_pc, tpc: target, taken: taken, dir_fail: dir_fail, add_fail: add_fail};
        full     = (fill_q == FILL_W'(UPD_DEPTH));
        pop      = upd_valid & upd_ready;
        push_ok  = resolve & (~full | pop);
        drop     = resolve & full & ~pop;
        remain   = fill_q - FILL_W'(pop);
        fill_d   = remain + FILL_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        head_d   = head_q;
        if (fill_d != '0) begin
            head_d = (remain == '0) ? new_rec : mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= new_rec;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            head_q    <= '0;
            upd_valid <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_q + PTR_W'(push_ok);
            fill_q    <= fill_d;
            head_q    <= head_d;
            upd_valid <= (fill_d != '0);
        end
    end

    assign upd_pc       = head_q.pc;
    assign upd_tpc      = head_q.tpc;
    assign upd_taken    = head_q.taken;
    assign upd_dir_fail = head_q.dir_fail;
    assign upd_add_fail = head_q.add_fail;

    // Saturating statistics counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            br_cnt   <= '0;
            miss_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (resolve && (br_cnt != '1)) begin
                br_cnt <= br_cnt + CNT_WIDTH'(1);
            end
            if (resolve && mispredict && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + CNT_WIDTH'(1);
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: vector table, hand sequences for FIFO/flush/reset corners,
// and random traffic checked against a queue-based reference model.
module tb_branch_resolve;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [3:0]  ex_br_op;
    logic [31:0] ex_rj;
    logic [31:0] ex_rd;
    logic [31:0] ex_offs;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_pc;
    logic        flush;
    logic [31:0] flush_pc;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic [31:0] upd_tpc;
    logic        upd_taken;
    logic        upd_dir_fail;
    logic        upd_add_fail;
    logic [31:0] br_cnt;
    logic [31:0] miss_cnt;
    logic [31:0] drop_cnt;

    branch_resolve #(.UPD_DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_br_op(ex_br_op),
        .ex_rj(ex_rj), .ex_rd(ex_rd), .ex_offs(ex_offs),
        .ex_pred_taken(ex_pred_taken), .ex_pred_pc(ex_pred_pc),
        .flush(flush), .flush_pc(flush_pc),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_tpc(upd_tpc), .upd_taken(upd_taken),
        .upd_dir_fail(upd_dir_fail), .upd_add_fail(upd_add_fail),
        .br_cnt(br_cnt), .miss_cnt(miss_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tpc;
        logic [2:0]  flags;
    } rec_t;

    rec_t        m_q[$];
    rec_t        m_head;
    bit          m_flush;
    logic [31:0] m_flush_pc;
    longint      m_br, m_miss, m_drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_q.delete();
        m_head     = '{pc: 32'd0, tpc: 32'd0, flags: 3'd0};
        m_flush    = 0;
        m_flush_pc = 32'd0;
        m_br = 0; m_miss = 0; m_drop = 0;
    endtask

    function automatic void ref_eval(input logic [3:0] op, input logic [31:0] rj, input logic [31:0] rd,
                                     input logic [31:0] pc, input logic [31:0] offs, input logic pt,
                                     input logic [31:0] ppc, output bit isbr, output bit tk,
                                     output logic [31:0] tgt, output bit df, output bit af,
                                     output logic [31:0] npc);
        int          sj, sd;
        longint unsigned sum;
        sj   = rj;
        sd   = rd;
        isbr = (op >= 4'd1) && (op <= 4'd9);
        case (op)
            4'd1:    tk = (rj == rd);
            4'd2:    tk = (rj != rd);
            4'd3:    tk = (sj < sd);
            4'd4:    tk = (sj >= sd);
            4'd5:    tk = (rj < rd);
            4'd6:    tk = (rj >= rd);
            default: tk = isbr;
        endcase
        sum = {32'd0, (op == 4'd9) ? rj : pc} + {32'd0, offs};
        tgt = sum[31:0];
        df  = (tk != pt);
        af  = tk && pt && (tgt != ppc);
        sum = {32'd0, pc} + 64'd4;
        npc = tk ? tgt : sum[31:0];
    endfunction

    task automatic check_outputs();
        chk("flush", {31'd0, flush}, {31'd0, m_flush});
        if (m_flush) chk("flush_pc", flush_pc, m_flush_pc);
        chk("upd_valid", {31'd0, upd_valid}, {31'd0, m_q.size() > 0});
        chk("upd_pc", upd_pc, m_head.pc);
        chk("upd_tpc", upd_tpc, m_head.tpc);
        chk("upd_flags", {29'd0, upd_taken, upd_dir_fail, upd_add_fail}, {29'd0, m_head.flags});
        chk("br_cnt", br_cnt, m_br[31:0]);
        chk("miss_cnt", miss_cnt, m_miss[31:0]);
        chk("drop_cnt", drop_cnt, m_drop[31:0]);
    endtask

    // One clock: predict from current inputs, advance, then compare every output
    task automatic tick();
        bit isbr, tk, df, af, res, pop, nf;
        logic [31:0] tgt, npc;
        int sz;
        ref_eval(ex_br_op, ex_rj, ex_rd, ex_pc, ex_offs, ex_pred_taken, ex_pred_pc,
                 isbr, tk, tgt, df, af, npc);
        res = ex_valid && isbr && !m_flush;
        sz  = m_q.size();
        pop = (sz > 0) && upd_ready;
        nf  = res && (df || af);
        @(posedge clk);
        #1;
        if (pop) void'(m_q.pop_front());
        if (res) begin
            if (sz < DEPTH || pop) m_q.push_back('{pc: ex_pc, tpc: tgt, flags: {tk, df, af}});
            else m_drop++;
            m_br++;
            if (df || af) m_miss++;
        end
        m_flush = nf;
        if (nf) m_flush_pc = npc;
        if (m_q.size() > 0) m_head = m_q[0];
        check_outputs();
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] rj, input logic [31:0] rd,
                         input logic [31:0] pc, input logic [31:0] offs, input logic pt,
                         input logic [31:0] ppc);
        ex_valid = 1'b1; ex_br_op = op; ex_rj = rj; ex_rd = rd;
        ex_pc = pc; ex_offs = offs; ex_pred_taken = pt; ex_pred_pc = ppc;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rj, rd, pc, offs;
        logic        pt;
        logic [31:0] ppc;
        logic        e_res, e_tk;
        logic [31:0] e_tgt;
        logic        e_df, e_af, e_fl;
        logic [31:0] e_fpc;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic [31:0] saved;
        logic [31:0] pcs[6];
        bit isbr, tk, df, af;
        logic [31:0] tgt, npc;

        //        op     rj            rd            pc            offs          pt    ppc           res   tk    tgt           df    af    fl    fpc
        vt[0] = '{4'd1,  32'd5,        32'd5,        32'h1C000100, 32'h40,       1'b1, 32'h1C000140, 1'b1, 1'b1, 32'h1C000140, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[1] = '{4'd3,  32'hFFFFFFFF, 32'd1,        32'h1C000200, 32'h80,       1'b0, 32'h0,        1'b1, 1'b1, 32'h1C000280, 1'b1, 1'b0, 1'b1, 32'h1C000280};
        vt[2] = '{4'd5,  32'hFFFFFFFF, 32'd1,        32'h1C000200, 32'h80,       1'b0, 32'h0,        1'b1, 1'b0, 32'h1C000280, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[3] = '{4'd9,  32'h1C002000, 32'd0,        32'h1C000300, 32'd8,        1'b1, 32'h1C003000, 1'b1, 1'b1, 32'h1C002008, 1'b0, 1'b1, 1'b1, 32'h1C002008};
        vt[4] = '{4'd7,  32'd0,        32'd0,        32'hFFFFFFF0, 32'h20,       1'b1, 32'h00000010, 1'b1, 1'b1, 32'h00000010, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[5] = '{4'd2,  32'd3,        32'd3,        32'h1C000400, 32'hFFFFFFF0, 1'b1, 32'h1C0003F0, 1'b1, 1'b0, 32'h1C0003F0, 1'b1, 1'b0, 1'b1, 32'h1C000404};
        vt[6] = '{4'd4,  32'hFFFFFFFE, 32'hFFFFFFFE, 32'h1C000500, 32'h10,       1'b1, 32'h1C000510, 1'b1, 1'b1, 32'h1C000510, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[7] = '{4'd6,  32'd1,        32'hFFFFFFFF, 32'h1C000600, 32'h10,       1'b0, 32'h0,        1'b1, 1'b0, 32'h1C000610, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[8] = '{4'd8,  32'd0,        32'd0,        32'h1C000700, 32'h100,      1'b0, 32'h0,        1'b1, 1'b1, 32'h1C000800, 1'b1, 1'b0, 1'b1, 32'h1C000800};
        vt[9] = '{4'd12, 32'd7,        32'd7,        32'h1C000800, 32'h10,       1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};

        rstn = 1'b0; ex_valid = 1'b0; ex_br_op = 4'd0; ex_rj = '0; ex_rd = '0;
        ex_pc = '0; ex_offs = '0; ex_pred_taken = 1'b0; ex_pred_pc = '0; upd_ready = 1'b1;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rstn = 1'b1;

        // Vector table, one branch at a time into an empty FIFO
        for (int i = 0; i < 10; i++) begin
            saved = br_cnt;
            drive(vt[i].op, vt[i].rj, vt[i].rd, vt[i].pc, vt[i].offs, vt[i].pt, vt[i].ppc);
            tick();
            chk("vec_flush", {31'd0, flush}, {31'd0, vt[i].e_fl});
            if (vt[i].e_fl) chk("vec_flush_pc", flush_pc, vt[i].e_fpc);
            chk("vec_upd_valid", {31'd0, upd_valid}, {31'd0, vt[i].e_res});
            chk("vec_br_cnt", br_cnt, saved + {31'd0, vt[i].e_res});
            if (vt[i].e_res) begin
                chk("vec_upd_pc", upd_pc, vt[i].pc);
                chk("vec_upd_tpc", upd_tpc, vt[i].e_tgt);
                chk("vec_upd_flags", {29'd0, upd_taken, upd_dir_fail, upd_add_fail},
                    {29'd0, vt[i].e_tk, vt[i].e_df, vt[i].e_af});
            end
            ex_valid = 1'b0;
            tick();
        end

        // A valid branch during the FLUSH cycle is discarded
        drive(vt[3].op, vt[3].rj, vt[3].rd, vt[3].pc, vt[3].offs, vt[3].pt, vt[3].ppc);
        tick();
        saved = br_cnt;
        drive(4'd1, 32'd5, 32'd5, 32'h1C000900, 32'h40, 1'b1, 32'h1C000940);
        tick();
        chk("flush_cycle_br_cnt", br_cnt, saved);
        chk("flush_cycle_flush", {31'd0, flush}, 32'd0);
        ex_valid = 1'b0;
        repeat (2) tick();

        // Fill with upd_ready low: 4 queued, fifth dropped
        upd_ready = 1'b0;
        saved = drop_cnt;
        for (int i = 0; i < 6; i++) pcs[i] = 32'h20000000 + 32'(i * 16);
        for (int i = 0; i < 5; i++) begin
            drive(4'd1, 32'd1, 32'd2, pcs[i], 32'd8, 1'b0, 32'h0);
            tick();
        end
        chk("fill_drop", drop_cnt, saved + 32'd1);
        chk("fill_head", upd_pc, pcs[0]);
        // Push into full FIFO together with a pop
        upd_ready = 1'b1;
        drive(4'd1, 32'd1, 32'd2, pcs[5], 32'd8, 1'b0, 32'h0);
        tick();
        chk("full_pushpop_drop", drop_cnt, saved + 32'd1);
        chk("drain_head1", upd_pc, pcs[1]);
        ex_valid = 1'b0;
        tick(); chk("drain_head2", upd_pc, pcs[2]);
        tick(); chk("drain_head3", upd_pc, pcs[3]);
        tick(); chk("drain_head5", upd_pc, pcs[5]);
        tick();
        chk("drain_empty", {31'd0, upd_valid}, 32'd0);
        chk("drain_hold", upd_pc, pcs[5]);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            ex_valid      = ($urandom_range(0, 3) != 0);
            ex_br_op      = 4'($urandom_range(0, 15));
            ex_rj         = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF + 32'($urandom_range(0, 2)) : $urandom;
            ex_rd         = ($urandom_range(0, 2) == 0) ? ex_rj : $urandom;
            ex_pc         = {$urandom, 2'b00};
            ex_offs       = ($urandom_range(0, 1) == 1) ? {{16{ex_rj[0]}}, 14'($urandom), 2'b00} : $urandom;
            ex_pred_taken = 1'($urandom_range(0, 1));
            ref_eval(ex_br_op, ex_rj, ex_rd, ex_pc, ex_offs, 1'b1, 32'h0, isbr, tk, tgt, df, af, npc);
            ex_pred_pc    = ($urandom_range(0, 1) == 1) ? tgt : $urandom;
            upd_ready     = ($urandom_range(0, 2) != 0);
            tick();
        end

        // Reset in the cycle after a mispredict
        upd_ready = 1'b0;
        drive(vt[1].op, vt[1].rj, vt[1].rd, vt[1].pc, vt[1].offs, vt[1].pt, vt[1].ppc);
        tick();
        chk("pre_reset_flush", {31'd0, flush}, 32'd1);
        ex_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        reset_model();
        check_outputs();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        upd_ready = 1'b1;
        drive(vt[0].op, vt[0].rj, vt[0].rd, vt[0].pc, vt[0].offs, vt[0].pt, vt[0].ppc);
        tick();
        ex_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
